vec_mem_reader: RTL
===================

// Module: vec_mem_reader
// PURPOSE
//  Read-side streamer for the memory-to-memory vector datapath: fetches LENGTH 16-bit elements from a
//  synchronous 1-cycle-latency data memory at BASE, BASE+STRIDE, ... and delivers them in order on a
//  valid/ready stream to the vector ALU. Counterpart of the write-enable element registers/writers.
// PARAMETERS
//  DATA_W  16  element width
//  ADDR_W  16  memory address width; address arithmetic wraps modulo 2^ADDR_W
//  LEN_W   8   width of length field; max vector length 2^LEN_W-1
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       launch request; sampled only in IDLE
//  base_addr  in   ADDR_W  first element address (captured on accepted start)
//  stride     in   ADDR_W  address increment between elements (captured on start)
//  length     in   LEN_W   element count (captured on start)
//  busy       out  1       high from cycle after accepted start until done pulse
//  done       out  1       one-cycle pulse when transfer completes
//  mem_en     out  1       memory read strobe (registered)
//  mem_addr   out  ADDR_W  memory read address (registered)
//  mem_rdata  in   DATA_W  read data; valid the cycle after a cycle with mem_en=1
//  out_data   out  DATA_W  stream element
//  out_valid  out  1       stream element valid
//  out_ready  in   1       consumer accepts when out_valid&out_ready
//  out_last   out  1       marks final element of the vector
// BEHAVIOUR
//  Reset: busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, FSM=IDLE,
//   counters cleared. Reset mid-transfer aborts: buffered/in-flight data discarded, rdata returning
//   the cycle after reset is ignored (in-flight flag cleared by reset).
//  FSM: IDLE -> RUN on start (length!=0); IDLE -> DONE on start with length==0 (no mem_en, no
//   stream beat); RUN -> DRAIN when LENGTH reads issued; DRAIN -> DONE when last beat handshaken;
//   DONE -> IDLE next cycle (done=1 exactly in DONE). start while busy is ignored.
//  Issue rule: read i (0-based) issued with mem_addr=base+i*stride (accumulated adder, wraps) only
//   when outstanding_reads + buffered_entries < 2, so the 2-entry buffer never overflows; no
//   combinational path from out_ready to mem_en beyond this credit check.
//  Throughput: with out_ready held 1, one element per cycle; first out_valid 2 cycles after start
//   (mem_en cycle+1 issue, +1 data capture).
//  Stream: out_data/out_valid/out_last held stable while out_valid&!out_ready. Elements delivered
//   in issue order; out_last=1 only on element LENGTH-1. out_valid=0 in IDLE/DONE.
//  Simultaneous push (rdata return) and pop (handshake) on the buffer in same cycle: both occur,
//   occupancy unchanged. Buffer full and pop: push allowed same cycle.
//  Counters: issue count and delivered count LEN_W bits; length=2^LEN_W-1 must not wrap early.
// STRUCTURE
//  Shared package vec_pkg: DATA_W/ADDR_W/LEN_W defaults, FSM state enum (IDLE,RUN,DRAIN,DONE).
//  Sub-module vec_skid_fifo: 2-entry FIFO of {last,data} with push/pop, full/empty, sync reset.
//  Top holds FSM, address accumulator, issue/deliver counters, in-flight flag/credit logic.
// TESTING
//  base=0x0010,stride=1,len=4,ready=1, mem[i]=0xA000+i -> addrs 10..13 on consecutive cycles,
//   out_data A010..A013 back-to-back, out_last on A013, done pulse 1 cycle later, busy then 0.
//  base=0xFFFE,stride=1,len=4 -> mem_addr FFFE,FFFF,0000,0001 (wrap), data in order.
//  len=6, out_ready toggling 1,0,0,1,... -> no element lost/duplicated, outputs stable while
//   stalled, mem_en never issued when 2 credits used; 6 beats total, last on 6th.
//  len=0 start -> no mem_en, no out_valid, done pulse, busy high 1 cycle only.
//  start pulsed again while busy (len=3 running) -> ignored; exactly 3 beats, one done.
//  rst asserted 1 cycle after second read issued -> all outputs reset values next cycle; returning
//   rdata not presented; subsequent start len=2 runs cleanly.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory reader: default widths and FSM states.
package vec_pkg;

   localparam int VEC_DATA_W = 16;
   localparam int VEC_ADDR_W = 16;
   localparam int VEC_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/vec_mem_reader_if.sv
// Memory read port plus the outgoing element stream of the vector reader.
interface vec_mem_reader_if
   import vec_pkg::*;
#(
   parameter int ADDR_W = VEC_ADDR_W,
   parameter int DATA_W = VEC_DATA_W
);

   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   // Reader side: drives the memory strobe/address and the stream.
   modport master (
      output mem_en, mem_addr, out_data, out_valid, out_last,
      input  mem_rdata, out_ready
   );

   // Memory and consumer side.
   modport slave (
      input  mem_en, mem_addr, out_data, out_valid, out_last,
      output mem_rdata, out_ready
   );

endinterface

// File: rtl/vec_skid_fifo.sv
// Two-entry FIFO holding {last, data} for elements the consumer has not yet taken.
module vec_skid_fifo #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;

   // Pointers and occupancy; a push and a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) r_wptr <= ~r_wptr;
         if (i_pop)  r_rptr <= ~r_rptr;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Element storage; contents are don't-care while the FIFO is empty, so no reset.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/vec_mem_reader.sv
// Strided vector fetch from a 1-cycle-latency memory, delivered in order on a valid/ready stream.
// Returning read data is presented directly when the buffer is empty, otherwise it queues behind
// the buffered elements; reads are issued only when the buffer is guaranteed room for them.
module vec_mem_reader
   import vec_pkg::*;
#(
   parameter int DATA_W = VEC_DATA_W,
   parameter int ADDR_W = VEC_ADDR_W,
   parameter int LEN_W  = VEC_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   vec_mem_reader_if.master  bus
);

   state_t            r_state;
   state_t            w_next;
   logic              w_start_acc;
   logic              w_issue;
   logic              w_pop;
   logic              w_last_beat;
   logic              w_credit_ok;
   logic              w_out_valid;

   logic              r_mem_en;
   logic              r_mem_last;
   logic              r_rvalid;
   logic              r_rlast;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_stride;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_issue_cnt;
   logic [LEN_W-1:0]  r_deliv_cnt;
   logic [LEN_W-1:0]  w_issue_nxt;

   logic              w_fifo_push;
   logic              w_fifo_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [DATA_W:0]   w_fifo_dout;
   logic [DATA_W:0]   w_head;
   logic [2:0]        w_buf_cnt;
   logic [2:0]        w_occ;

   vec_skid_fifo #(.W(DATA_W + 1)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_data  ({r_rlast, bus.mem_rdata}),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Stream head: buffered element if any, else the element returning from memory this cycle.
   assign w_out_valid   = ~w_fifo_empty | r_rvalid;
   assign w_head        = w_fifo_empty ? {r_rlast, bus.mem_rdata} : w_fifo_dout;
   assign w_pop         = w_out_valid & bus.out_ready;
   assign w_fifo_pop    = w_pop & ~w_fifo_empty;
   assign w_fifo_push   = r_rvalid & ~(w_fifo_empty & bus.out_ready);
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? w_head[DATA_W-1:0] : '0;
   assign bus.out_last  = w_out_valid & w_head[DATA_W];
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_addr  = r_mem_addr;

   // Credit: buffered + returning + requested elements, less the one leaving now, must stay below 2.
   assign w_buf_cnt   = w_fifo_full ? 3'd2 : (w_fifo_empty ? 3'd0 : 3'd1);
   assign w_occ       = w_buf_cnt + {2'b00, r_rvalid} + {2'b00, r_mem_en};
   assign w_credit_ok = (w_occ < (3'd2 + {2'b00, w_pop}));

   assign w_issue_nxt = r_issue_cnt + LEN_W'(1);
   assign w_issue     = (r_state == ST_RUN) && (r_issue_cnt != r_len) && w_credit_ok;
   assign w_last_beat = w_pop && (r_deliv_cnt == (r_len - LEN_W'(1)));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode and status outputs.
   always_comb begin
      w_next      = r_state;
      w_start_acc = 1'b0;
      busy        = (r_state != ST_IDLE);
      done        = (r_state == ST_DONE);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_next      = (length == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN:   if (r_issue_cnt == r_len) w_next = ST_DRAIN;
         ST_DRAIN: if (w_last_beat) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Read issue, address accumulation, in-flight tracking and element counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_en    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_last  <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rlast     <= 1'b0;
         r_addr      <= '0;
         r_stride    <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_deliv_cnt <= '0;
      end else begin
         r_rvalid <= r_mem_en;
         r_rlast  <= r_mem_last;
         r_mem_en <= 1'b0;
         if (w_start_acc) begin
            r_stride    <= stride;
            r_len       <= length;
            r_deliv_cnt <= '0;
            if (length != '0) begin
               r_mem_en    <= 1'b1;
               r_mem_addr  <= base_addr;
               r_mem_last  <= (length == LEN_W'(1));
               r_addr      <= base_addr + stride;
               r_issue_cnt <= LEN_W'(1);
            end else begin
               r_issue_cnt <= '0;
            end
         end else if (w_issue) begin
            r_mem_en    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_last  <= (w_issue_nxt == r_len);
            r_addr      <= r_addr + r_stride;
            r_issue_cnt <= w_issue_nxt;
         end
         if (w_pop) r_deliv_cnt <= r_deliv_cnt + LEN_W'(1);
      end
   end

endmodule
